execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
- Execute stage of the pipelined RV32I core. Sits directly downstream of the decode stage's ID/EX register and upstream of the memory stage.
- Selects forwarded operands, performs the ALU operation, and computes the branch/jump target and the zero flag. The zero flag goes back to decode for PC-source generation.
- Registers all results and control into the integrated EX/MEM pipeline register.

Parameters:
- DATA_WIDTH, 32, datapath width
- ADDR_WIDTH, 5, register address width
- PC_WIDTH, 11, program counter width

Ports:
- i_clk  in  1  clock, all state updates on rising edge
- i_rst  in  1  synchronous active-high reset
- i_regwrite_e  in  1  register write enable from ID/EX
- i_resultsrc_e  in  2  result select (00 ALU, 01 memory, 10 PC+4)
- i_memwrite_e  in  1  data-memory write enable
- i_aluctrl_e  in  alu_op_t  ALU operation
- i_alusrc_e  in  1  0: operand B = forwarded rs2; 1: immediate
- i_storetype_e  in  3  store width code (funct3), passed through
- i_rs1_data_e  in  DATA_WIDTH  rs1 value from regfile
- i_rs2_data_e  in  DATA_WIDTH  rs2 value from regfile
- i_immext_e  in  DATA_WIDTH  extended immediate
- i_pc_e  in  PC_WIDTH  instruction PC
- i_pc4_e  in  PC_WIDTH  PC+4
- i_rd_addr_e  in  ADDR_WIDTH  destination register
- i_forward_a_e  in  2  rs1 forward select from hazard unit
- i_forward_b_e  in  2  rs2 forward select from hazard unit
- i_result_w  in  DATA_WIDTH  writeback-stage result
- o_zero_e  out  1  combinational: ALU result == 0
- o_pctarget_e  out  PC_WIDTH  combinational: branch/jump target
- o_regwrite_m  out  1  EX/MEM register write enable
- o_resultsrc_m  out  2  EX/MEM result select
- o_memwrite_m  out  1  EX/MEM memory write enable
- o_storetype_m  out  3  EX/MEM store type
- o_alu_result_m  out  DATA_WIDTH  EX/MEM ALU result; also the M-stage forward source
- o_write_data_m  out  DATA_WIDTH  EX/MEM store data
- o_rd_addr_m  out  ADDR_WIDTH  EX/MEM destination register
- o_pc4_m  out  PC_WIDTH  EX/MEM PC+4

Behaviour:
- Clock and reset: one clock, i_clk; reset is i_rst, synchronous and active-high. No asynchronous reset path.

Forwarding (combinational):
- srcA = i_rs1_data_e (00), i_result_w (01), o_alu_result_m (10).
- Code 11 is illegal; it selects i_rs1_data_e and must not produce X.
- The forwarded rs2 uses the same mux driven by i_forward_b_e.

Operand B:
- srcB = i_immext_e when i_alusrc_e = 1, else forwarded rs2.
- Store data (to o_write_data_m) is always the forwarded rs2, independent of i_alusrc_e.

ALU (combinational, results mod 2^DATA_WIDTH):
- ADD a+b; SUB a-b.
- AND, OR, XOR bitwise.
- SLT: signed compare, result 1/0. SLTU: unsigned compare, result 1/0.
- SLL, SRL, SRA: shift amount is b[4:0]; SRA sign-fills.
- ALU_UNUSED or any other code: result 0.

Combinational outputs:
- o_zero_e = (alu_result == 0).
- o_pctarget_e = (i_pc_e + i_immext_e[PC_WIDTH-1:0]) mod 2^PC_WIDTH; wraps silently.

EX/MEM register:
- Latency: one cycle from inputs to *_m outputs.
- Every rising edge with i_rst = 0 loads all *_m outputs from the current-cycle values. There is no stall or flush input; bubbles arrive as zeroed control from decode.
- With i_rst = 1 at an edge, all *_m outputs are cleared to 0, including o_storetype_m = 3'b000.
- This also applies mid-stream: the following cycle presents a full bubble, with o_regwrite_m = o_memwrite_m = 0.

Forward source:
- The M-stage forward source is the registered o_alu_result_m. Back-to-back dependent ALU ops therefore need no stall.

Test Plan:
- Reset held, then released:
  - all *_m = 0 after the first edge with i_rst = 1;
  - i_rst asserted mid-stream with o_regwrite_m = 1 -> o_regwrite_m = 0 next cycle.
- ADD with rs1 = 5, imm = 0xFFFFFFFB, alusrc = 1:
  - o_zero_e = 1;
  - o_alu_result_m = 0 one cycle later.
- SUB with rs1 = 7, rs2 = 7 -> o_zero_e = 1. Change rs2 to 8 -> result 0xFFFFFFFF, o_zero_e = 0.
- SLT vs SLTU with a = 0xFFFFFFFF, b = 1 -> SLT gives 1, SLTU gives 0. SRA of 0x80000000 by 4 -> 0xF8000000.
- Forwarding:
  - cycle N ADD produces 0x10; cycle N+1 forward_a = 10 and ADD imm 1 -> o_alu_result_m = 0x11;
  - forward_b = 01 with i_result_w = 0xABCD and memwrite = 1 -> o_write_data_m = 0xABCD.
- Target wrap: i_pc_e = 11'h7FC, imm = 8 -> o_pctarget_e = 11'h004. Passthrough: i_pc4_e = 11'h100 -> o_pc4_m = 11'h100 after one cycle.

Source files
------------

// File: rtl/execute_stage.sv
// Execute stage of the RV32I pipeline: operand forwarding, ALU, branch target,
// zero flag, and the EX/MEM pipeline register.
package execute_pkg;
  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_AND    = 4'd2,
    ALU_OR     = 4'd3,
    ALU_XOR    = 4'd4,
    ALU_SLT    = 4'd5,
    ALU_SLTU   = 4'd6,
    ALU_SLL    = 4'd7,
    ALU_SRL    = 4'd8,
    ALU_SRA    = 4'd9,
    ALU_UNUSED = 4'd15
  } alu_op_t;
endpackage

module execute_stage
  import execute_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int PC_WIDTH   = 11
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_regwrite_e,
  input  logic [1:0]            i_resultsrc_e,
  input  logic                  i_memwrite_e,
  input  alu_op_t               i_aluctrl_e,
  input  logic                  i_alusrc_e,
  input  logic [2:0]            i_storetype_e,
  input  logic [DATA_WIDTH-1:0] i_rs1_data_e,
  input  logic [DATA_WIDTH-1:0] i_rs2_data_e,
  input  logic [DATA_WIDTH-1:0] i_immext_e,
  input  logic [PC_WIDTH-1:0]   i_pc_e,
  input  logic [PC_WIDTH-1:0]   i_pc4_e,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr_e,
  input  logic [1:0]            i_forward_a_e,
  input  logic [1:0]            i_forward_b_e,
  input  logic [DATA_WIDTH-1:0] i_result_w,
  output logic                  o_zero_e,
  output logic [PC_WIDTH-1:0]   o_pctarget_e,
  output logic                  o_regwrite_m,
  output logic [1:0]            o_resultsrc_m,
  output logic                  o_memwrite_m,
  output logic [2:0]            o_storetype_m,
  output logic [DATA_WIDTH-1:0] o_alu_result_m,
  output logic [DATA_WIDTH-1:0] o_write_data_m,
  output logic [ADDR_WIDTH-1:0] o_rd_addr_m,
  output logic [PC_WIDTH-1:0]   o_pc4_m
);

  logic [DATA_WIDTH-1:0] src_a;
  logic [DATA_WIDTH-1:0] fwd_b;
  logic [DATA_WIDTH-1:0] src_b;
  logic [DATA_WIDTH-1:0] alu_result;
  logic signed [DATA_WIDTH-1:0] src_a_s;
  logic signed [DATA_WIDTH-1:0] src_b_s;
  logic [4:0] shamt;

  logic                  regwrite_q,   regwrite_d;
  logic [1:0]            resultsrc_q,  resultsrc_d;
  logic                  memwrite_q,   memwrite_d;
  logic [2:0]            storetype_q,  storetype_d;
  logic [DATA_WIDTH-1:0] alu_result_q, alu_result_d;
  logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q,    rd_addr_d;
  logic [PC_WIDTH-1:0]   pc4_q,        pc4_d;

  // Illegal forward code 2'b11 falls back to the register-file value.
  always_comb begin
    case (i_forward_a_e)
      2'b01:   src_a = i_result_w;
      2'b10:   src_a = alu_result_q;
      default: src_a = i_rs1_data_e;
    endcase
    case (i_forward_b_e)
      2'b01:   fwd_b = i_result_w;
      2'b10:   fwd_b = alu_result_q;
      default: fwd_b = i_rs2_data_e;
    endcase
  end

  assign src_b   = i_alusrc_e ? i_immext_e : fwd_b;
  assign src_a_s = src_a;
  assign src_b_s = src_b;
  assign shamt   = src_b[4:0];

  always_comb begin
    alu_result = '0;
    case (i_aluctrl_e)
      ALU_ADD:  alu_result = src_a + src_b;
      ALU_SUB:  alu_result = src_a - src_b;
      ALU_AND:  alu_result = src_a & src_b;
      ALU_OR:   alu_result = src_a | src_b;
      ALU_XOR:  alu_result = src_a ^ src_b;
      ALU_SLT:  alu_result = {{(DATA_WIDTH-1){1'b0}}, (src_a_s < src_b_s)};
      ALU_SLTU: alu_result = {{(DATA_WIDTH-1){1'b0}}, (src_a < src_b)};
      ALU_SLL:  alu_result = src_a << shamt;
      ALU_SRL:  alu_result = src_a >> shamt;
      ALU_SRA:  alu_result = src_a_s >>> shamt;
      default:  alu_result = '0;
    endcase
  end

  assign o_zero_e     = (alu_result == '0);
  assign o_pctarget_e = i_pc_e + i_immext_e[PC_WIDTH-1:0];

  // EX -> MEM boundary
  always_comb begin
    regwrite_d   = i_regwrite_e;
    resultsrc_d  = i_resultsrc_e;
    memwrite_d   = i_memwrite_e;
    storetype_d  = i_storetype_e;
    alu_result_d = alu_result;
    write_data_d = fwd_b;
    rd_addr_d    = i_rd_addr_e;
    pc4_d        = i_pc4_e;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      regwrite_q   <= 1'b0;
      resultsrc_q  <= '0;
      memwrite_q   <= 1'b0;
      storetype_q  <= '0;
      alu_result_q <= '0;
      write_data_q <= '0;
      rd_addr_q    <= '0;
      pc4_q        <= '0;
    end else begin
      regwrite_q   <= regwrite_d;
      resultsrc_q  <= resultsrc_d;
      memwrite_q   <= memwrite_d;
      storetype_q  <= storetype_d;
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      rd_addr_q    <= rd_addr_d;
      pc4_q        <= pc4_d;
    end
  end

  assign o_regwrite_m   = regwrite_q;
  assign o_resultsrc_m  = resultsrc_q;
  assign o_memwrite_m   = memwrite_q;
  assign o_storetype_m  = storetype_q;
  assign o_alu_result_m = alu_result_q;
  assign o_write_data_m = write_data_q;
  assign o_rd_addr_m    = rd_addr_q;
  assign o_pc4_m        = pc4_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed, table-driven bench for execute_stage.
module tb_execute_stage;
  import execute_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        regwrite_e;
  logic [1:0]  resultsrc_e;
  logic        memwrite_e;
  alu_op_t     aluctrl_e;
  logic        alusrc_e;
  logic [2:0]  storetype_e;
  logic [31:0] rs1_e, rs2_e, imm_e, result_w;
  logic [10:0] pc_e, pc4_e;
  logic [4:0]  rd_e;
  logic [1:0]  fa_e, fb_e;
  logic        zero_e;
  logic [10:0] pctarget_e;
  logic        regwrite_m, memwrite_m;
  logic [1:0]  resultsrc_m;
  logic [2:0]  storetype_m;
  logic [31:0] alu_m, wd_m;
  logic [4:0]  rd_m;
  logic [10:0] pc4_m;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  execute_stage dut (
    .i_clk(clk), .i_rst(rst),
    .i_regwrite_e(regwrite_e), .i_resultsrc_e(resultsrc_e), .i_memwrite_e(memwrite_e),
    .i_aluctrl_e(aluctrl_e), .i_alusrc_e(alusrc_e), .i_storetype_e(storetype_e),
    .i_rs1_data_e(rs1_e), .i_rs2_data_e(rs2_e), .i_immext_e(imm_e),
    .i_pc_e(pc_e), .i_pc4_e(pc4_e), .i_rd_addr_e(rd_e),
    .i_forward_a_e(fa_e), .i_forward_b_e(fb_e), .i_result_w(result_w),
    .o_zero_e(zero_e), .o_pctarget_e(pctarget_e),
    .o_regwrite_m(regwrite_m), .o_resultsrc_m(resultsrc_m), .o_memwrite_m(memwrite_m),
    .o_storetype_m(storetype_m), .o_alu_result_m(alu_m), .o_write_data_m(wd_m),
    .o_rd_addr_m(rd_m), .o_pc4_m(pc4_m)
  );

  typedef struct {
    alu_op_t     op;
    logic        alusrc;
    logic [31:0] rs1, rs2, imm;
    logic [1:0]  fa, fb;
    logic [31:0] resw;
    logic [10:0] pc;
    logic        ez;
    logic [10:0] etgt;
    logic [31:0] ealu, ewd;
  } vec_t;

  vec_t tv[$];

  task automatic add_v(input alu_op_t op, input logic alusrc, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] imm, input logic [1:0] fa,
                       input logic [1:0] fb, input logic [31:0] resw, input logic [10:0] pc,
                       input logic ez, input logic [10:0] etgt, input logic [31:0] ealu,
                       input logic [31:0] ewd);
    vec_t v;
    v.op = op; v.alusrc = alusrc; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
    v.fa = fa; v.fb = fb; v.resw = resw; v.pc = pc;
    v.ez = ez; v.etgt = etgt; v.ealu = ealu; v.ewd = ewd;
    tv.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    regwrite_e = 0; resultsrc_e = 0; memwrite_e = 0; aluctrl_e = ALU_ADD;
    alusrc_e = 0; storetype_e = 0; rs1_e = 0; rs2_e = 0; imm_e = 0;
    pc_e = 0; pc4_e = 0; rd_e = 0; fa_e = 0; fb_e = 0; result_w = 0;
  endtask

  initial begin
    // op alusrc rs1 rs2 imm fa fb resw pc | zero tgt alu wdata
    add_v(ALU_ADD,    1, 32'h5,        32'h3,    32'hFFFFFFFB, 0, 0, 0,       11'h010, 1, 11'h00B, 32'h0,        32'h3);
    add_v(ALU_SUB,    0, 32'h7,        32'h7,    32'h0,        0, 0, 0,       11'h010, 1, 11'h010, 32'h0,        32'h7);
    add_v(ALU_SUB,    0, 32'h7,        32'h8,    32'h0,        0, 0, 0,       11'h010, 0, 11'h010, 32'hFFFFFFFF, 32'h8);
    add_v(ALU_SLT,    0, 32'hFFFFFFFF, 32'h1,    32'h0,        0, 0, 0,       11'h010, 0, 11'h010, 32'h1,        32'h1);
    add_v(ALU_SLTU,   0, 32'hFFFFFFFF, 32'h1,    32'h0,        0, 0, 0,       11'h010, 1, 11'h010, 32'h0,        32'h1);
    add_v(ALU_SRA,    1, 32'h80000000, 32'h0,    32'h4,        0, 0, 0,       11'h010, 0, 11'h014, 32'hF8000000, 32'h0);
    add_v(ALU_ADD,    1, 32'h8,        32'h0,    32'h8,        0, 0, 0,       11'h010, 0, 11'h018, 32'h10,       32'h0);
    add_v(ALU_ADD,    1, 32'h999,      32'h0,    32'h1,        2, 0, 0,       11'h010, 0, 11'h011, 32'h11,       32'h0);
    add_v(ALU_ADD,    1, 32'h100,      32'h55,   32'h4,        0, 1, 32'hABCD,11'h010, 0, 11'h014, 32'h104,      32'hABCD);
    add_v(ALU_SUB,    0, 32'h777,      32'h10,   32'h0,        1, 0, 32'h50,  11'h010, 0, 11'h010, 32'h40,       32'h10);
    add_v(ALU_ADD,    0, 32'h20,       32'h3,    32'h0,        3, 3, 32'h1000,11'h010, 0, 11'h010, 32'h23,       32'h3);
    add_v(ALU_ADD,    1, 32'h0,        32'h0,    32'h8,        0, 0, 0,       11'h7FC, 0, 11'h004, 32'h8,        32'h0);
    add_v(ALU_AND,    0, 32'hF0F0,     32'hFF00, 32'h0,        0, 0, 0,       11'h010, 0, 11'h010, 32'hF000,     32'hFF00);
    add_v(ALU_OR,     0, 32'hF0F0,     32'hFF00, 32'h0,        0, 0, 0,       11'h010, 0, 11'h010, 32'hFFF0,     32'hFF00);
    add_v(ALU_XOR,    0, 32'hF0F0,     32'hFF00, 32'h0,        0, 0, 0,       11'h010, 0, 11'h010, 32'h0FF0,     32'hFF00);
    add_v(ALU_SLL,    1, 32'h1,        32'h0,    32'h25,       0, 0, 0,       11'h010, 0, 11'h035, 32'h20,       32'h0);
    add_v(ALU_SRL,    1, 32'h80000000, 32'h0,    32'h4,        0, 0, 0,       11'h010, 0, 11'h014, 32'h08000000, 32'h0);
    add_v(ALU_ADD,    0, 32'h1,        32'h7,    32'h0,        0, 2, 0,       11'h010, 0, 11'h010, 32'h08000001, 32'h08000000);
    add_v(ALU_UNUSED, 0, 32'h5,        32'h6,    32'h0,        0, 0, 0,       11'h010, 1, 11'h010, 32'h0,        32'h6);

    // Reset with junk on the inputs: everything registered must clear.
    drive_idle();
    rst = 1; regwrite_e = 1; memwrite_e = 1; storetype_e = 3'h7; resultsrc_e = 2'h2;
    rs1_e = 32'h1234; rd_e = 5'h1F; pc4_e = 11'h3FF; rs2_e = 32'h55;
    @(posedge clk); #1;
    check("rst_regwrite",  32'(regwrite_m),  0);
    check("rst_memwrite",  32'(memwrite_m),  0);
    check("rst_resultsrc", 32'(resultsrc_m), 0);
    check("rst_storetype", 32'(storetype_m), 0);
    check("rst_alu",       alu_m,            0);
    check("rst_wdata",     wd_m,             0);
    check("rst_rd",        32'(rd_m),        0);
    check("rst_pc4",       32'(pc4_m),       0);

    @(negedge clk);
    rst = 0;
    foreach (tv[i]) begin
      @(negedge clk);
      aluctrl_e = tv[i].op; alusrc_e = tv[i].alusrc; rs1_e = tv[i].rs1; rs2_e = tv[i].rs2;
      imm_e = tv[i].imm; fa_e = tv[i].fa; fb_e = tv[i].fb; result_w = tv[i].resw; pc_e = tv[i].pc;
      regwrite_e = i[0]; memwrite_e = i[1]; resultsrc_e = 2'(i % 3);
      storetype_e = 3'(i % 8); rd_e = 5'(i + 1); pc4_e = 11'(11'h0F5 + i);
      #1;
      check($sformatf("v%0d_zero", i),   32'(zero_e),     32'(tv[i].ez));
      check($sformatf("v%0d_target", i), 32'(pctarget_e), 32'(tv[i].etgt));
      @(posedge clk); #1;
      check($sformatf("v%0d_alu", i),       alu_m,             tv[i].ealu);
      check($sformatf("v%0d_wdata", i),     wd_m,              tv[i].ewd);
      check($sformatf("v%0d_regwrite", i),  32'(regwrite_m),   32'(i % 2));
      check($sformatf("v%0d_memwrite", i),  32'(memwrite_m),   32'((i / 2) % 2));
      check($sformatf("v%0d_resultsrc", i), 32'(resultsrc_m),  32'(i % 3));
      check($sformatf("v%0d_storetype", i), 32'(storetype_m),  32'(i % 8));
      check($sformatf("v%0d_rd", i),        32'(rd_m),         32'(i + 1));
      check($sformatf("v%0d_pc4", i),       32'(pc4_m),        32'(11'h0F5 + i));
    end

    // Mid-stream reset: a live write in EX/MEM becomes a bubble.
    @(negedge clk);
    drive_idle();
    regwrite_e = 1; memwrite_e = 1; storetype_e = 3'h2; rs1_e = 32'h33; imm_e = 32'h1; alusrc_e = 1;
    pc4_e = 11'h100;
    @(posedge clk); #1;
    check("mid_regwrite_pre", 32'(regwrite_m), 1);
    check("mid_alu_pre",      alu_m,           32'h34);
    check("mid_pc4_pre",      32'(pc4_m),      32'h100);
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    check("mid_regwrite", 32'(regwrite_m),  0);
    check("mid_memwrite", 32'(memwrite_m),  0);
    check("mid_storetype",32'(storetype_m), 0);
    check("mid_alu",      alu_m,            0);
    check("mid_pc4",      32'(pc4_m),       0);

    // After reset, forwarding from M must see the cleared result.
    @(negedge clk);
    rst = 0; fa_e = 2'b10; alusrc_e = 1; imm_e = 32'h5; aluctrl_e = ALU_ADD;
    #1;
    check("post_rst_fwd_zero", 32'(zero_e), 0);
    @(posedge clk); #1;
    check("post_rst_fwd_alu", alu_m, 32'h5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish before 100000");
    $fatal(1);
  end
endmodule
